// File: rtl/ic_trace_pkg.sv
// Purpose     : shared types and constants for the ic_trace monitor.
// Latency     : n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   IC_DROP_CNT_W        width of the saturating drop counter
//   ic_ch_w()            channel-index width, never below 1
//   ic_trace_entry_t     trace entry {ch, data, ts, ovf} at the default geometry
//   `IC_TRACE_ENTRY_T    same entry layout for any channel/data/timestamp width
package ic_trace_pkg;

    localparam int IC_DROP_CNT_W = 16;

    localparam int IC_DEF_NUM_CH = 4;
    localparam int IC_DEF_DATA_W = 32;
    localparam int IC_DEF_TS_W   = 32;

    // A single channel still needs a 1-bit index field.
    function automatic int ic_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef struct packed {
        logic [ic_ch_w(IC_DEF_NUM_CH)-1:0] ch;
        logic [IC_DEF_DATA_W-1:0]          data;
        logic [IC_DEF_TS_W-1:0]            ts;
        logic                              ovf;
    } ic_trace_entry_t;

endpackage

// Parametrised form of ic_trace_entry_t, for instances that override the default geometry.
`define IC_TRACE_ENTRY_T(CHW, DW, TSW) struct packed { logic [(CHW)-1:0] ch; logic [(DW)-1:0] data; logic [(TSW)-1:0] ts; logic ovf; }

// File: rtl/ic_trace_fifo.sv
// Purpose     : synchronous first-word-fallthrough FIFO for trace entries.
// Latency     : a push is visible on rdata the cycle after it is written.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, wdata     write strobe and entry
//   full            no free entry
//   pop             consume the head entry (ignored when empty)
//   rdata, empty    head entry (zero while empty) and empty flag
//   level           current occupancy, 0..DEPTH
module ic_trace_fifo
    import ic_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

    assign rd_en = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);

    // Head is gated so the outputs read as zero while nothing is queued.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ic_trace_mon.sv
// Purpose     : multi-channel trace monitor; timestamps channel samples and streams them out.
// Latency     : a sample in cycle N reaches tr_* in cycle N+2 at the earliest.
// Backpressure: tr_ready low fills the FIFO, then the hold regs; further samples are dropped and counted.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en, on_change       capture enable; capture only changed values
//   ch_valid, ch_data   per-channel strobe and sample (channel i at [i*DATA_W +: DATA_W])
//   tr_valid, tr_ready  trace stream handshake
//   tr_ch, tr_data,     source channel, sample, capture timestamp,
//   tr_ts, tr_ovf       and "samples on this channel were dropped before this entry"
//   drop_cnt            saturating total of dropped samples
//   level               trace FIFO occupancy
//
// Build option: define IC_TRACE_PRINT_EN to log every trace handshake with $display
// (simulation-only). Without it the block is plain RTL; ports and timing are identical.
module ic_trace_mon
    import ic_trace_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       on_change,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [ic_ch_w(NUM_CH)-1:0] tr_ch,
    output logic [DATA_W-1:0]          tr_data,
    output logic [TS_W-1:0]            tr_ts,
    output logic                       tr_ovf,
    output logic [IC_DROP_CNT_W-1:0]   drop_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int CH_W  = ic_ch_w(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef `IC_TRACE_ENTRY_T(CH_W, DATA_W, TS_W) entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Free-running timestamp, independent of en.
    logic [TS_W-1:0]          ts_q;

    // Per-channel one-deep hold register in front of the arbiter.
    logic [NUM_CH-1:0]        hold_vld;
    logic [DATA_W-1:0]        hold_data [NUM_CH];
    logic [TS_W-1:0]          hold_ts   [NUM_CH];

    // Last accepted value per channel, for on_change filtering.
    logic [NUM_CH-1:0]        last_vld;
    logic [DATA_W-1:0]        last_data [NUM_CH];

    logic [NUM_CH-1:0]        ovf_pend;
    logic [CH_W-1:0]          rr_ptr;
    logic [IC_DROP_CNT_W-1:0] drop_cnt_q;

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        accept;
    logic [NUM_CH-1:0]        drop;
    logic [NUM_CH-1:0]        gnt_oh;
    logic                     gnt_any;
    logic [CH_W-1:0]          gnt_ch;
    logic [IC_DROP_CNT_W:0]   drop_sum;

    entry_t                   push_entry;
    entry_t                   pop_entry;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [LVL_W-1:0]         fifo_level;

    // ------------------------------------------------------------------
    // Capture requests
    // ------------------------------------------------------------------
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = en & ch_valid[i] &
                     (~on_change | ~last_vld[i] |
                      (ch_data[i*DATA_W +: DATA_W] != last_data[i]));
        end
    end

    // A busy hold reg can still take a new sample in the cycle it drains.
    assign accept = req & (~hold_vld | gnt_oh);
    assign drop   = req & ~accept;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first scan from rr_ptr upward, then wrap to the
    // low channels. Nothing is granted while the FIFO is full.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_oh  = '0;
        gnt_any = 1'b0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_any && hold_vld[i] && (i >= int'(rr_ptr))) begin
                    gnt_oh[i] = 1'b1;
                    gnt_any   = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_any && hold_vld[i]) begin
                    gnt_oh[i] = 1'b1;
                    gnt_any   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_ch     = '0;
        push_entry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) begin
                gnt_ch          = CH_W'(i);
                push_entry.ch   = CH_W'(i);
                push_entry.data = hold_data[i];
                push_entry.ts   = hold_ts[i];
                push_entry.ovf  = ovf_pend[i];
            end
        end
    end

    // Several channels can drop in one cycle; the total saturates.
    assign drop_sum = {1'b0, drop_cnt_q} + (IC_DROP_CNT_W+1)'($countones(drop));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q       <= '0;
            hold_vld   <= '0;
            last_vld   <= '0;
            ovf_pend   <= '0;
            rr_ptr     <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_data[i] <= '0;
                hold_ts[i]   <= '0;
                last_data[i] <= '0;
            end
        end else begin
            ts_q <= ts_q + TS_W'(1);

            if (gnt_any) begin
                if (int'(gnt_ch) == NUM_CH - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt_ch + CH_W'(1);
                end
            end

            drop_cnt_q <= drop_sum[IC_DROP_CNT_W] ? '1 : drop_sum[IC_DROP_CNT_W-1:0];

            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    hold_vld[i]  <= 1'b1;
                    hold_data[i] <= ch_data[i*DATA_W +: DATA_W];
                    hold_ts[i]   <= ts_q;
                    last_vld[i]  <= 1'b1;
                    last_data[i] <= ch_data[i*DATA_W +: DATA_W];
                end else if (gnt_oh[i]) begin
                    hold_vld[i]  <= 1'b0;
                end

                // A drop in the same cycle as the push keeps the flag for the next entry.
                if (drop[i]) begin
                    ovf_pend[i] <= 1'b1;
                end else if (gnt_oh[i]) begin
                    ovf_pend[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Trace FIFO and output stream
    // ------------------------------------------------------------------
    assign fifo_pop = ~fifo_empty & tr_ready;

    ic_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt_any),
        .wdata (push_entry),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .rdata (pop_entry),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tr_valid = ~fifo_empty;
    assign tr_ch    = pop_entry.ch;
    assign tr_data  = pop_entry.data;
    assign tr_ts    = pop_entry.ts;
    assign tr_ovf   = pop_entry.ovf;
    assign drop_cnt = drop_cnt_q;
    assign level    = fifo_level;

`ifdef IC_TRACE_PRINT_EN
    // Simulation-only handshake log, one line per accepted trace entry.
    always @(posedge clk) begin
        if (rst_n && tr_valid && tr_ready) begin
            $display("IC_SV:: @%0t ch%0d ts:%0d (%0h)%s", $time, tr_ch, tr_ts, tr_data,
                     tr_ovf ? " OVF" : "");
        end
    end
`endif

endmodule

// File: tb/tb_ic_trace_mon.sv
// Purpose     : directed self-checking bench for ic_trace_mon (4 channels, 32-bit data, depth 16).
// Latency     : n/a.
// Backpressure: n/a.
module tb_ic_trace_mon;

    localparam int NV = 52;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         on_change;
    logic [3:0]   ch_valid;
    logic [127:0] ch_data;
    logic         tr_valid;
    logic         tr_ready;
    logic [1:0]   tr_ch;
    logic [31:0]  tr_data;
    logic [31:0]  tr_ts;
    logic         tr_ovf;
    logic [15:0]  drop_cnt;
    logic [4:0]   level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ic_trace_mon #(
        .NUM_CH (4),
        .DATA_W (32),
        .DEPTH  (16),
        .TS_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .on_change (on_change),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .tr_valid  (tr_valid),
        .tr_ready  (tr_ready),
        .tr_ch     (tr_ch),
        .tr_data   (tr_data),
        .tr_ts     (tr_ts),
        .tr_ovf    (tr_ovf),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    // One row per cycle: inputs driven in that cycle, outputs expected in it.
    // Row r is the cycle whose timestamp is r after the reset release.
    typedef struct {
        logic         en;
        logic         onc;
        logic [3:0]   vld;
        logic [127:0] dat;
        logic         rdy;
        logic         e_vld;
        logic [1:0]   e_ch;
        logic [31:0]  e_data;
        logic [31:0]  e_ts;
        logic [4:0]   e_lvl;
    } vec_t;

    vec_t tv [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_one(input int r, input int ch, input logic [31:0] d);
        tv[r].vld = 4'(1 << ch);
        tv[r].dat[ch*32 +: 32] = d;
    endtask

    task automatic set_all(input int r, input logic [31:0] base);
        tv[r].vld = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tv[r].dat[i*32 +: 32] = base + 32'(i);
        end
    endtask

    task automatic exp_e(input int r, input int ch, input logic [31:0] d, input int ts);
        tv[r].e_vld  = 1'b1;
        tv[r].e_ch   = 2'(ch);
        tv[r].e_data = d;
        tv[r].e_ts   = 32'(ts);
        tv[r].e_lvl  = 5'd1;
    endtask

    task automatic set_idle();
        en        = 1'b1;
        on_change = 1'b0;
        ch_valid  = '0;
        ch_data   = '0;
    endtask

    // Called on a falling edge; returns on the falling edge of the ts=0 cycle.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        set_idle();
    endtask

    logic [31:0] oc_seq [6];
    int          n;

    initial begin
        // ---------------- vector table ----------------
        for (int r = 0; r < NV; r++) begin
            tv[r].en     = 1'b1;
            tv[r].onc    = 1'b0;
            tv[r].vld    = '0;
            tv[r].dat    = '0;
            tv[r].rdy    = 1'b1;
            tv[r].e_vld  = 1'b0;
            tv[r].e_ch   = '0;
            tv[r].e_data = '0;
            tv[r].e_ts   = '0;
            tv[r].e_lvl  = '0;
        end
        // Single sample on ch1 at ts=10, visible at ts=12.
        set_one(10, 1, 32'hA5A5_0001);
        exp_e(12, 1, 32'hA5A5_0001, 10);
        // ch3 alone moves the pointer to 0.
        set_one(14, 3, 32'h0000_3003);
        exp_e(16, 3, 32'h0000_3003, 14);
        // Burst on all channels: order 0,1,2,3, one timestamp.
        set_all(17, 32'h0000_1000);
        for (int k = 0; k < 4; k++) exp_e(19 + k, k, 32'h0000_1000 + 32'(k), 17);
        // ch1 alone moves the pointer to 2; next burst comes out 2,3,0,1.
        set_one(24, 1, 32'h0000_0B01);
        exp_e(26, 1, 32'h0000_0B01, 24);
        set_all(27, 32'h0000_2000);
        exp_e(29, 2, 32'h0000_2002, 27);
        exp_e(30, 3, 32'h0000_2003, 27);
        exp_e(31, 0, 32'h0000_2000, 27);
        exp_e(32, 1, 32'h0000_2001, 27);
        // on_change=1, ch2 data 5,5,5,7,7,5 -> entries 5,7,5 only.
        oc_seq[0] = 32'd5; oc_seq[1] = 32'd5; oc_seq[2] = 32'd5;
        oc_seq[3] = 32'd7; oc_seq[4] = 32'd7; oc_seq[5] = 32'd5;
        for (int k = 0; k < 6; k++) begin
            tv[34 + k].onc = 1'b1;
            set_one(34 + k, 2, oc_seq[k]);
        end
        exp_e(36, 2, 32'd5, 34);
        exp_e(39, 2, 32'd7, 37);
        exp_e(41, 2, 32'd5, 39);
        // Same data with on_change=0 -> all six entries.
        for (int k = 0; k < 6; k++) begin
            set_one(43 + k, 2, oc_seq[k]);
            exp_e(45 + k, 2, oc_seq[k], 43 + k);
        end

        // ---------------- reset with all channels strobing ----------------
        rst_n     = 1'b0;
        en        = 1'b1;
        on_change = 1'b0;
        ch_valid  = '1;
        ch_data   = '1;
        tr_ready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_tr_valid", 64'(tr_valid), 64'd0);
            chk("rst_level", 64'(level), 64'd0);
            chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        end
        rst_n = 1'b1;
        set_idle();
        chk("rst_tr_data", 64'(tr_data), 64'd0);
        chk("rst_tr_ts", 64'(tr_ts), 64'd0);
        chk("rst_tr_ch", 64'(tr_ch), 64'd0);
        chk("rst_tr_ovf", 64'(tr_ovf), 64'd0);

        // ---------------- table run ----------------
        for (int r = 0; r < NV; r++) begin
            chk($sformatf("row%0d_tr_valid", r), 64'(tr_valid), 64'(tv[r].e_vld));
            chk($sformatf("row%0d_level", r), 64'(level), 64'(tv[r].e_lvl));
            chk($sformatf("row%0d_drop_cnt", r), 64'(drop_cnt), 64'd0);
            if (tv[r].e_vld) begin
                chk($sformatf("row%0d_tr_ch", r), 64'(tr_ch), 64'(tv[r].e_ch));
                chk($sformatf("row%0d_tr_data", r), 64'(tr_data), 64'(tv[r].e_data));
                chk($sformatf("row%0d_tr_ts", r), 64'(tr_ts), 64'(tv[r].e_ts));
                chk($sformatf("row%0d_tr_ovf", r), 64'(tr_ovf), 64'd0);
            end
            en        = tv[r].en;
            on_change = tv[r].onc;
            ch_valid  = tv[r].vld;
            ch_data   = tv[r].dat;
            tr_ready  = tv[r].rdy;
            @(negedge clk);
        end

        // ---------------- overflow: sink stalled, ch0 every cycle for 40 cycles ----------------
        do_reset(2);
        tr_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ch_valid = 4'b0001;
            ch_data  = 128'(i);
            @(negedge clk);
        end
        ch_valid = '0;
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd23);
        tr_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (tr_valid) begin
                chk($sformatf("ovf_entry%0d_data", n), 64'(tr_data), 64'(n));
                chk($sformatf("ovf_entry%0d_flag", n), 64'(tr_ovf), 64'(n == 16));
                n++;
            end
            @(negedge clk);
        end
        chk("ovf_entry_count", 64'(n), 64'd17);

        // ---------------- mid-stream reset ----------------
        tr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ch_valid = 4'b0001;
            ch_data  = 128'(100 + i);
            @(negedge clk);
        end
        ch_valid = '0;
        repeat (2) @(negedge clk);
        chk("mid_level_before", 64'(level), 64'd8);
        chk("mid_drop_before", 64'(drop_cnt), 64'd23);
        chk("mid_head_before", 64'(tr_data), 64'd100);
        do_reset(1);
        chk("mid_tr_valid", 64'(tr_valid), 64'd0);
        chk("mid_level", 64'(level), 64'd0);
        chk("mid_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mid_tr_data", 64'(tr_data), 64'd0);
        // Same value as the last pre-reset capture must pass on_change: history was cleared.
        on_change = 1'b1;
        ch_valid  = 4'b0001;
        ch_data   = 128'(107);
        @(negedge clk);
        ch_valid  = '0;
        chk("mid_lat1_tr_valid", 64'(tr_valid), 64'd0);
        @(negedge clk);
        chk("mid_post_tr_valid", 64'(tr_valid), 64'd1);
        chk("mid_post_tr_ts", 64'(tr_ts), 64'd0);
        chk("mid_post_tr_data", 64'(tr_data), 64'd107);
        chk("mid_post_tr_ch", 64'(tr_ch), 64'd0);
        chk("mid_post_tr_ovf", 64'(tr_ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
